// File: rtl/divider_radix2_responder.sv
// Iterative unsigned restoring divider on the execute-stage valid/done handshake.
// Produces one quotient bit per cycle; c = {remainder, quotient}, done pulses once.
module divider_radix2_responder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   c,
  output logic                 done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       trial;
  logic                 trial_ge;
  logic [WIDTH:0]       trial_diff;
  logic [WIDTH:0]       step_rem;
  logic [WIDTH-1:0]     step_quot;

  // One restoring step: bring down the next dividend bit and try to subtract.
  assign trial      = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
  assign trial_ge   = (trial >= {1'b0, divisor_q});
  assign trial_diff = trial - {1'b0, divisor_q};
  assign step_rem   = trial_ge ? trial_diff : trial;
  assign step_quot  = {quot_q[WIDTH-2:0], trial_ge};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      c_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath; done_d is asserted only on the transition into DONE.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          dividend_d = a;
          divisor_d  = b;
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          rem_d      = step_rem;
          quot_d     = step_quot;
          dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            c_d     = {step_rem[WIDTH-1:0], step_quot};
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign c    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_divider_radix2_responder.sv
// Directed bench for divider_radix2_responder: scoreboard of expected {rem, quot}
// popped on each done pulse, plus latency, abort, back-to-back and reset checks.
module tb_divider_radix2_responder;

  localparam int unsigned W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   c;
  logic             done;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int seen_done = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_c = '0;

  divider_radix2_responder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .a     (a),
    .b     (b),
    .c     (c),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (done === 1'b1) seen_done++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    if (y == '0) return {x, {W{1'b1}}};
    return {x % y, x / y};
  endfunction

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    valid = 1'b1;
    a     = x;
    b     = y;
    if (push) sb.push_back(model(x, y));
  endtask

  // Wait (bounded) for the done pulse; it must land exactly in cycle n.
  task automatic expect_done(input string tag, input int n);
    logic [2*W-1:0] exp;
    tick();
    while (done !== 1'b1 && cyc < n + 20) tick();
    chk({tag, "_cycle"}, (2*W)'(cyc), (2*W)'(n));
    exp = (sb.size() > 0) ? sb.pop_front() : ~c;
    chk({tag, "_c"}, c, exp);
    last_c = exp;
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    tick();
    chk("rst_done", (2*W)'(done), '0);
    chk("rst_c", c, '0);
    reset = 1'b1;
    tick();

    // 100/7 with valid held, then valid drops in the DONE cycle
    cyc = 0;
    start(64'd100, 64'd7, 1'b1);
    expect_done("div100_7", 65);
    chk("div100_7_ref", last_c, {64'd2, 64'd14});
    valid = 1'b0;
    tick();
    chk("post_done_low", (2*W)'(done), '0);
    tick(); tick(); tick();
    chk("c_retained", c, last_c);

    // Boundary operands
    cyc = 0;
    start(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    expect_done("max_by_1", 65);
    valid = 1'b0;
    tick();
    cyc = 0;
    start(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    expect_done("small_by_max", 65);
    valid = 1'b0;
    tick();
    cyc = 0;
    start(64'd1234, 64'd0, 1'b1);
    expect_done("div_by_zero", 65);
    chk("div_by_zero_ref", last_c, {64'd1234, 64'hFFFF_FFFF_FFFF_FFFF});
    valid = 1'b0;
    tick();

    // Back-to-back with valid held; operands switched in the DONE cycle
    cyc = 0;
    start(64'd100, 64'd7, 1'b1);
    expect_done("b2b_first", 65);
    start(64'd81, 64'd9, 1'b1);
    tick();
    chk("b2b_done_low_66", (2*W)'(done), '0);
    expect_done("b2b_second", 131);
    chk("b2b_second_ref", last_c, {64'd0, 64'd9});
    valid = 1'b0;
    tick();

    // Abort at cycle 30, restart at cycle 40 with new operands
    cyc = 0;
    seen_done = 0;
    start(64'd100, 64'd7, 1'b0);
    tick_to(30);
    valid = 1'b0;
    tick_to(35);
    chk("abort_c_held", c, last_c);
    tick_to(40);
    start(64'd50, 64'd3, 1'b1);
    tick_to(104);
    chk("abort_no_early_done", (2*W)'(seen_done), '0);
    chk("abort_c_held_104", c, last_c);
    expect_done("abort_restart", 105);
    chk("abort_restart_ref", last_c, {64'd2, 64'd16});
    valid = 1'b0;
    tick();

    // Reset in the middle of an operation
    cyc = 0;
    start(64'd200, 64'd9, 1'b0);
    tick_to(20);
    reset = 1'b0;
    valid = 1'b0;
    tick();
    chk("rst_mid_done", (2*W)'(done), '0);
    chk("rst_mid_c", c, '0);
    reset = 1'b1;
    tick();
    cyc = 0;
    start(64'd77, 64'd5, 1'b1);
    expect_done("after_rst", 65);

    // Reset coinciding with the DONE cycle
    reset = 1'b0;
    valid = 1'b0;
    tick();
    chk("rst_done_cycle_done", (2*W)'(done), '0);
    chk("rst_done_cycle_c", c, '0);
    reset = 1'b1;
    tick();
    chk("rst_idle_done", (2*W)'(done), '0);
    chk("sb_empty", (2*W)'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
